// File: rtl/aes_pkg.sv
// Shared AES state types, FSM encoding and column-major layout helpers.
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  localparam int unsigned NumCols = 4;
  localparam int unsigned NumRows = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  // Column c occupies bits [127-32c -: 32]; row r of a column is bits [31-8r -: 8].
  function automatic word_t get_col(state_t s, logic [1:0] c);
    return s[127 - 32 * int'(c) -: 32];
  endfunction

  function automatic state_t set_col(state_t s, logic [1:0] c, word_t w);
    state_t res;
    res = s;
    res[127 - 32 * int'(c) -: 32] = w;
    return res;
  endfunction

  // Output row r, column c takes input row r, column (c + r) mod 4.
  function automatic state_t shift_rows(state_t s);
    state_t res;
    res = '0;
    for (int c = 0; c < NumCols; c++) begin
      for (int r = 0; r < NumRows; r++) begin
        res[127 - 32 * c - 8 * r -: 8] = s[127 - 32 * ((c + r) % NumCols) - 8 * r -: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_subshift_if.sv
// Valid/ready handshake bundle between the upstream producer, this stage and MixColumns.
interface aes_subshift_if;

  logic            in_valid;
  logic            in_ready;
  aes_pkg::state_t in_state;
  logic            out_valid;
  logic            out_ready;
  aes_pkg::state_t out_state;

  // Environment side: drives the input state and the downstream ready.
  modport master (
    output in_valid,
    output in_state,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_state
  );

  // Stage side.
  modport slave (
    input  in_valid,
    input  in_state,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_state
  );

endinterface

// File: rtl/aes_sbox.sv
// FIPS-197 forward S-box as a combinational case-table ROM.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Pure table lookup, one entry per input byte value.
  always_comb begin
    o_byte = 8'h00;
    case (i_byte)
      8'h00: o_byte = 8'h63; 8'h01: o_byte = 8'h7c; 8'h02: o_byte = 8'h77; 8'h03: o_byte = 8'h7b;
      8'h04: o_byte = 8'hf2; 8'h05: o_byte = 8'h6b; 8'h06: o_byte = 8'h6f; 8'h07: o_byte = 8'hc5;
      8'h08: o_byte = 8'h30; 8'h09: o_byte = 8'h01; 8'h0a: o_byte = 8'h67; 8'h0b: o_byte = 8'h2b;
      8'h0c: o_byte = 8'hfe; 8'h0d: o_byte = 8'hd7; 8'h0e: o_byte = 8'hab; 8'h0f: o_byte = 8'h76;
      8'h10: o_byte = 8'hca; 8'h11: o_byte = 8'h82; 8'h12: o_byte = 8'hc9; 8'h13: o_byte = 8'h7d;
      8'h14: o_byte = 8'hfa; 8'h15: o_byte = 8'h59; 8'h16: o_byte = 8'h47; 8'h17: o_byte = 8'hf0;
      8'h18: o_byte = 8'had; 8'h19: o_byte = 8'hd4; 8'h1a: o_byte = 8'ha2; 8'h1b: o_byte = 8'haf;
      8'h1c: o_byte = 8'h9c; 8'h1d: o_byte = 8'ha4; 8'h1e: o_byte = 8'h72; 8'h1f: o_byte = 8'hc0;
      8'h20: o_byte = 8'hb7; 8'h21: o_byte = 8'hfd; 8'h22: o_byte = 8'h93; 8'h23: o_byte = 8'h26;
      8'h24: o_byte = 8'h36; 8'h25: o_byte = 8'h3f; 8'h26: o_byte = 8'hf7; 8'h27: o_byte = 8'hcc;
      8'h28: o_byte = 8'h34; 8'h29: o_byte = 8'ha5; 8'h2a: o_byte = 8'he5; 8'h2b: o_byte = 8'hf1;
      8'h2c: o_byte = 8'h71; 8'h2d: o_byte = 8'hd8; 8'h2e: o_byte = 8'h31; 8'h2f: o_byte = 8'h15;
      8'h30: o_byte = 8'h04; 8'h31: o_byte = 8'hc7; 8'h32: o_byte = 8'h23; 8'h33: o_byte = 8'hc3;
      8'h34: o_byte = 8'h18; 8'h35: o_byte = 8'h96; 8'h36: o_byte = 8'h05; 8'h37: o_byte = 8'h9a;
      8'h38: o_byte = 8'h07; 8'h39: o_byte = 8'h12; 8'h3a: o_byte = 8'h80; 8'h3b: o_byte = 8'he2;
      8'h3c: o_byte = 8'heb; 8'h3d: o_byte = 8'h27; 8'h3e: o_byte = 8'hb2; 8'h3f: o_byte = 8'h75;
      8'h40: o_byte = 8'h09; 8'h41: o_byte = 8'h83; 8'h42: o_byte = 8'h2c; 8'h43: o_byte = 8'h1a;
      8'h44: o_byte = 8'h1b; 8'h45: o_byte = 8'h6e; 8'h46: o_byte = 8'h5a; 8'h47: o_byte = 8'ha0;
      8'h48: o_byte = 8'h52; 8'h49: o_byte = 8'h3b; 8'h4a: o_byte = 8'hd6; 8'h4b: o_byte = 8'hb3;
      8'h4c: o_byte = 8'h29; 8'h4d: o_byte = 8'he3; 8'h4e: o_byte = 8'h2f; 8'h4f: o_byte = 8'h84;
      8'h50: o_byte = 8'h53; 8'h51: o_byte = 8'hd1; 8'h52: o_byte = 8'h00; 8'h53: o_byte = 8'hed;
      8'h54: o_byte = 8'h20; 8'h55: o_byte = 8'hfc; 8'h56: o_byte = 8'hb1; 8'h57: o_byte = 8'h5b;
      8'h58: o_byte = 8'h6a; 8'h59: o_byte = 8'hcb; 8'h5a: o_byte = 8'hbe; 8'h5b: o_byte = 8'h39;
      8'h5c: o_byte = 8'h4a; 8'h5d: o_byte = 8'h4c; 8'h5e: o_byte = 8'h58; 8'h5f: o_byte = 8'hcf;
      8'h60: o_byte = 8'hd0; 8'h61: o_byte = 8'hef; 8'h62: o_byte = 8'haa; 8'h63: o_byte = 8'hfb;
      8'h64: o_byte = 8'h43; 8'h65: o_byte = 8'h4d; 8'h66: o_byte = 8'h33; 8'h67: o_byte = 8'h85;
      8'h68: o_byte = 8'h45; 8'h69: o_byte = 8'hf9; 8'h6a: o_byte = 8'h02; 8'h6b: o_byte = 8'h7f;
      8'h6c: o_byte = 8'h50; 8'h6d: o_byte = 8'h3c; 8'h6e: o_byte = 8'h9f; 8'h6f: o_byte = 8'ha8;
      8'h70: o_byte = 8'h51; 8'h71: o_byte = 8'ha3; 8'h72: o_byte = 8'h40; 8'h73: o_byte = 8'h8f;
      8'h74: o_byte = 8'h92; 8'h75: o_byte = 8'h9d; 8'h76: o_byte = 8'h38; 8'h77: o_byte = 8'hf5;
      8'h78: o_byte = 8'hbc; 8'h79: o_byte = 8'hb6; 8'h7a: o_byte = 8'hda; 8'h7b: o_byte = 8'h21;
      8'h7c: o_byte = 8'h10; 8'h7d: o_byte = 8'hff; 8'h7e: o_byte = 8'hf3; 8'h7f: o_byte = 8'hd2;
      8'h80: o_byte = 8'hcd; 8'h81: o_byte = 8'h0c; 8'h82: o_byte = 8'h13; 8'h83: o_byte = 8'hec;
      8'h84: o_byte = 8'h5f; 8'h85: o_byte = 8'h97; 8'h86: o_byte = 8'h44; 8'h87: o_byte = 8'h17;
      8'h88: o_byte = 8'hc4; 8'h89: o_byte = 8'ha7; 8'h8a: o_byte = 8'h7e; 8'h8b: o_byte = 8'h3d;
      8'h8c: o_byte = 8'h64; 8'h8d: o_byte = 8'h5d; 8'h8e: o_byte = 8'h19; 8'h8f: o_byte = 8'h73;
      8'h90: o_byte = 8'h60; 8'h91: o_byte = 8'h81; 8'h92: o_byte = 8'h4f; 8'h93: o_byte = 8'hdc;
      8'h94: o_byte = 8'h22; 8'h95: o_byte = 8'h2a; 8'h96: o_byte = 8'h90; 8'h97: o_byte = 8'h88;
      8'h98: o_byte = 8'h46; 8'h99: o_byte = 8'hee; 8'h9a: o_byte = 8'hb8; 8'h9b: o_byte = 8'h14;
      8'h9c: o_byte = 8'hde; 8'h9d: o_byte = 8'h5e; 8'h9e: o_byte = 8'h0b; 8'h9f: o_byte = 8'hdb;
      8'ha0: o_byte = 8'he0; 8'ha1: o_byte = 8'h32; 8'ha2: o_byte = 8'h3a; 8'ha3: o_byte = 8'h0a;
      8'ha4: o_byte = 8'h49; 8'ha5: o_byte = 8'h06; 8'ha6: o_byte = 8'h24; 8'ha7: o_byte = 8'h5c;
      8'ha8: o_byte = 8'hc2; 8'ha9: o_byte = 8'hd3; 8'haa: o_byte = 8'hac; 8'hab: o_byte = 8'h62;
      8'hac: o_byte = 8'h91; 8'had: o_byte = 8'h95; 8'hae: o_byte = 8'he4; 8'haf: o_byte = 8'h79;
      8'hb0: o_byte = 8'he7; 8'hb1: o_byte = 8'hc8; 8'hb2: o_byte = 8'h37; 8'hb3: o_byte = 8'h6d;
      8'hb4: o_byte = 8'h8d; 8'hb5: o_byte = 8'hd5; 8'hb6: o_byte = 8'h4e; 8'hb7: o_byte = 8'ha9;
      8'hb8: o_byte = 8'h6c; 8'hb9: o_byte = 8'h56; 8'hba: o_byte = 8'hf4; 8'hbb: o_byte = 8'hea;
      8'hbc: o_byte = 8'h65; 8'hbd: o_byte = 8'h7a; 8'hbe: o_byte = 8'hae; 8'hbf: o_byte = 8'h08;
      8'hc0: o_byte = 8'hba; 8'hc1: o_byte = 8'h78; 8'hc2: o_byte = 8'h25; 8'hc3: o_byte = 8'h2e;
      8'hc4: o_byte = 8'h1c; 8'hc5: o_byte = 8'ha6; 8'hc6: o_byte = 8'hb4; 8'hc7: o_byte = 8'hc6;
      8'hc8: o_byte = 8'he8; 8'hc9: o_byte = 8'hdd; 8'hca: o_byte = 8'h74; 8'hcb: o_byte = 8'h1f;
      8'hcc: o_byte = 8'h4b; 8'hcd: o_byte = 8'hbd; 8'hce: o_byte = 8'h8b; 8'hcf: o_byte = 8'h8a;
      8'hd0: o_byte = 8'h70; 8'hd1: o_byte = 8'h3e; 8'hd2: o_byte = 8'hb5; 8'hd3: o_byte = 8'h66;
      8'hd4: o_byte = 8'h48; 8'hd5: o_byte = 8'h03; 8'hd6: o_byte = 8'hf6; 8'hd7: o_byte = 8'h0e;
      8'hd8: o_byte = 8'h61; 8'hd9: o_byte = 8'h35; 8'hda: o_byte = 8'h57; 8'hdb: o_byte = 8'hb9;
      8'hdc: o_byte = 8'h86; 8'hdd: o_byte = 8'hc1; 8'hde: o_byte = 8'h1d; 8'hdf: o_byte = 8'h9e;
      8'he0: o_byte = 8'he1; 8'he1: o_byte = 8'hf8; 8'he2: o_byte = 8'h98; 8'he3: o_byte = 8'h11;
      8'he4: o_byte = 8'h69; 8'he5: o_byte = 8'hd9; 8'he6: o_byte = 8'h8e; 8'he7: o_byte = 8'h94;
      8'he8: o_byte = 8'h9b; 8'he9: o_byte = 8'h1e; 8'hea: o_byte = 8'h87; 8'heb: o_byte = 8'he9;
      8'hec: o_byte = 8'hce; 8'hed: o_byte = 8'h55; 8'hee: o_byte = 8'h28; 8'hef: o_byte = 8'hdf;
      8'hf0: o_byte = 8'h8c; 8'hf1: o_byte = 8'ha1; 8'hf2: o_byte = 8'h89; 8'hf3: o_byte = 8'h0d;
      8'hf4: o_byte = 8'hbf; 8'hf5: o_byte = 8'he6; 8'hf6: o_byte = 8'h42; 8'hf7: o_byte = 8'h68;
      8'hf8: o_byte = 8'h41; 8'hf9: o_byte = 8'h99; 8'hfa: o_byte = 8'h2d; 8'hfb: o_byte = 8'h0f;
      8'hfc: o_byte = 8'hb0; 8'hfd: o_byte = 8'h54; 8'hfe: o_byte = 8'hbb; 8'hff: o_byte = 8'h16;
      default: o_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/aes_subshift.sv
// Column-serial SubBytes + ShiftRows stage: one column through four S-boxes per cycle,
// then the ShiftRows-permuted state is held on the output until the consumer takes it.
module aes_subshift
  import aes_pkg::*;
#(
  parameter int unsigned SBOX_REG = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  aes_subshift_if.slave  bus,
  output logic           busy
);

  // Only the combinational S-box path exists; any other SBOX_REG fails elaboration.
  if (SBOX_REG != 0) begin : gen_sbox_reg_check
    $error("aes_subshift: SBOX_REG must be 0");
  end

  fsm_e       r_fsm;
  logic [1:0] r_col;
  state_t     r_st;
  logic       r_out_valid;
  logic       r_busy;

  word_t      w_col_in;
  word_t      w_col_sub;

  // The current column is muxed out of the state register by the column counter.
  assign w_col_in = get_col(r_st, r_col);

  for (genvar g = 0; g < NumRows; g++) begin : gen_sbox
    aes_sbox u_sbox (
      .i_byte (w_col_in[31 - 8 * g -: 8]),
      .o_byte (w_col_sub[31 - 8 * g -: 8])
    );
  end

  // Accept in IDLE, or in DONE when the current result leaves this same cycle.
  assign bus.in_ready  = (r_fsm == IDLE) || ((r_fsm == DONE) && bus.out_ready);
  assign bus.out_valid = r_out_valid;
  assign bus.out_state = shift_rows(r_st);
  assign busy          = r_busy;

  // FSM, column counter, state register and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= IDLE;
      r_col       <= 2'd0;
      r_st        <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_fsm)
        IDLE: begin
          if (bus.in_valid) begin
            r_st   <= bus.in_state;
            r_col  <= 2'd0;
            r_fsm  <= SUB;
            r_busy <= 1'b1;
          end
        end
        SUB: begin
          // in_valid is ignored here; the producer holds its state until in_ready.
          r_st  <= set_col(r_st, r_col, w_col_sub);
          r_col <= r_col + 2'd1;
          if (r_col == 2'd3) begin
            r_fsm       <= DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            if (bus.in_valid) begin
              // Back-to-back: next state loads in the hand-off cycle, no bubble.
              r_st        <= bus.in_state;
              r_col       <= 2'd0;
              r_fsm       <= SUB;
              r_busy      <= 1'b1;
              r_out_valid <= 1'b0;
            end else begin
              r_fsm       <= IDLE;
              r_out_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_fsm       <= IDLE;
          r_col       <= 2'd0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_subshift.sv
// Scoreboard bench for aes_subshift: S-box model computed from GF(2^8) inversion + affine map.
module tb_aes_subshift;

  typedef struct {
    logic [127:0] exp;
    int unsigned  acc;
  } sb_t;

  logic clk;
  logic rst_n;
  logic busy;

  aes_subshift_if bus ();

  aes_subshift #(
    .SBOX_REG (0)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc    = 0;
  int unsigned n_sent = 0;
  int unsigned n_recv = 0;
  bit          rand_rdy  = 1'b0;
  bit          rdy_force = 1'b1;
  sb_t         sb_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Sole writer of out_ready; updated mid-cycle so it is settled at the sampling edge.
  initial forever begin
    @(posedge clk);
    #2;
    bus.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [7:0]   m [4][4];
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = sbox_ref(s[127 - 32 * c - 8 * r -: 8]);
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127 - 32 * c - 8 * r -: 8] = m[r][(c + r) % 4];
    return res;
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24]; a1 = w[23:16]; a2 = w[15:8]; a3 = w[7:0];
    return {gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3,
            a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3,
            a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3),
            gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2)};
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    bit           new_out    = 1'b1;
    bit           prev_stall = 1'b0;
    logic [127:0] prev_state = '0;
    sb_t          item;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        new_out    = 1'b1;
        prev_stall = 1'b0;
      end else if (bus.out_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected no output", bus.out_state);
        end else begin
          if (new_out) begin
            new_out = 1'b0;
            chk("latency", 128'(cyc - sb_q[0].acc), 128'd5);
          end
          if (prev_stall) chk("stall_stable", bus.out_state, prev_state);
          if (bus.out_ready) begin
            item = sb_q.pop_front();
            chk("scoreboard", bus.out_state, item.exp);
            n_recv++;
            new_out    = 1'b1;
            prev_stall = 1'b0;
          end else begin
            prev_stall = 1'b1;
            prev_state = bus.out_state;
          end
        end
      end else if (prev_stall) begin
        checks++;
        errors++;
        $display("FAIL valid_dropped: got out_valid=0 expected 1 while stalled");
        prev_stall = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [127:0] s, output int unsigned acc);
    bit ok;
    int n;
    sb_t item;
    ok = 1'b0;
    n = 0;
    acc = 0;
    bus.in_valid = 1'b1;
    bus.in_state = s;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        acc = cyc;
        item.exp = model(s);
        item.acc = cyc;
        sb_q.push_back(item);
        n_sent++;
      end else begin
        n++;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_state = rand_state();
  endtask

  // Returns at the first negedge with out_valid high.
  task automatic wait_out(output logic [127:0] st);
    bit ok;
    ok = 1'b0;
    st = '0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1;
        st = bus.out_state;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL output_timeout: got out_valid=0 expected 1 within 50 cycles");
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 128'(bus.in_ready), 128'd1);
    chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'd0);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_out_state"}, bus.out_state, 128'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned  acc;
    int unsigned  c0;
    logic [127:0] st;
    logic [127:0] held;

    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_state = '0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // FIPS-197 App. B round 1
    send(128'h193de3bea0f4e22b9ac68d2ae9f84808, acc);
    wait_out(st);
    chk("fips_result", st, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    chk("fips_mixcol0", 128'(mixcol(st[127:96])), 128'h046681e5);
    @(negedge clk);
    chk("fips_one_cycle", 128'(bus.out_valid), 128'd0);
    @(posedge clk);
    #1;

    // All-zero state
    send(128'd0, acc);
    wait_out(st);
    chk("zero_result", st, {16{8'h63}});
    @(posedge clk);
    #1;

    // Counting pattern, model only
    send(128'h00112233445566778899aabbccddeeff, acc);
    wait_out(st);
    @(posedge clk);
    #1;

    // Backpressure for 7 cycles, then same-cycle release and accept
    rdy_force = 1'b0;
    send(rand_state(), acc);
    wait_out(held);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(bus.out_valid), 128'd1);
      chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
      chk("bp_out_state", bus.out_state, held);
    end
    @(posedge clk);
    #1;
    rdy_force = 1'b1;
    c0 = cyc;
    send(rand_state(), acc);
    chk("bp_no_bubble", 128'(acc), 128'(c0));
    wait_out(st);
    @(posedge clk);
    #1;

    // in_valid and in_state noise during SUB
    send(rand_state(), acc);
    for (int i = 0; i < 4; i++) begin
      chk("noise_busy", 128'(busy), 128'd1);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_state = rand_state();
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    wait_out(st);
    @(posedge clk);
    #1;

    // Asynchronous reset on the second SUB cycle
    send(rand_state(), acc);
    @(posedge clk);
    #3;
    chk("abort_busy_before", 128'(busy), 128'd1);
    rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_output", 128'(bus.out_valid), 128'd0);
    end
    @(posedge clk);
    #1;
    send(rand_state(), acc);
    wait_out(st);
    @(posedge clk);
    #1;

    // Streaming with random stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(rand_state(), acc);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    for (int i = 0; i < 500 && sb_q.size() != 0; i++) @(posedge clk);
    rand_rdy = 1'b0;
    chk("drain_empty", 128'(sb_q.size()), 128'd0);
    chk("sent_vs_recv", 128'(n_recv), 128'(n_sent - 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
